cpu_seq_ctrl: RTL and testbench

//  Multi-cycle control sequencer for the 8-bit CPU datapath (PC, AR, DR, IR, AC, ALU, Z flag reg).

---
 rtl/cpu_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - multi-cycle fetch/decode/execute control sequencer for the 8-bit CPU datapath
module cpu_seq_ctrl #(
  parameter int OP_W     = 4,
  parameter int ALUSEL_W = 3,
  parameter int ST_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_W-1:0]     ir_op,
  input  logic                zflag,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                arload,
  output logic                arsel,
  output logic                pcinc,
  output logic                pcload,
  output logic                drload,
  output logic                irload,
  output logic                acload,
  output logic                zload,
  output logic [ALUSEL_W-1:0] alusel,
  output logic                halted,
  output logic [ST_W-1:0]     dbg_state
);

  typedef enum logic [ST_W-1:0] {
    S_INIT = ST_W'(0),
    S_F1   = ST_W'(1),
    S_F2   = ST_W'(2),
    S_F3   = ST_W'(3),
    S_DEC  = ST_W'(4),
    S_O1   = ST_W'(5),
    S_O2   = ST_W'(6),
    S_XLD  = ST_W'(7),
    S_XST  = ST_W'(8),
    S_XALU = ST_W'(9),
    S_XJMP = ST_W'(10),
    S_HALT = ST_W'(11)
  } state_t;

  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(4'h0);
  localparam logic [OP_W-1:0] OP_LDAC = OP_W'(4'h1);
  localparam logic [OP_W-1:0] OP_STAC = OP_W'(4'h2);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(4'h3);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(4'h4);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(4'h5);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(4'h6);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4'h7);
  localparam logic [OP_W-1:0] OP_NOT  = OP_W'(4'h8);
  localparam logic [OP_W-1:0] OP_INC  = OP_W'(4'h9);
  localparam logic [OP_W-1:0] OP_JUMP = OP_W'(4'hA);
  localparam logic [OP_W-1:0] OP_JMPZ = OP_W'(4'hB);
  localparam logic [OP_W-1:0] OP_JPNZ = OP_W'(4'hC);
  localparam logic [OP_W-1:0] OP_NOPD = OP_W'(4'hD);
  localparam logic [OP_W-1:0] OP_NOPE = OP_W'(4'hE);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(4'hF);

  state_t state_q, state_d;
  logic   is_branch;
  logic   [ALUSEL_W-1:0] alu_fn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  assign is_branch = (ir_op == OP_JUMP) || (ir_op == OP_JMPZ) || (ir_op == OP_JPNZ);

  // LDAC reuses the ALU as a pass-through of DR into AC.
  always_comb begin
    alu_fn = ALUSEL_W'(0);
    case (ir_op)
      OP_LDAC: alu_fn = ALUSEL_W'(0);
      OP_ADD:  alu_fn = ALUSEL_W'(1);
      OP_SUB:  alu_fn = ALUSEL_W'(2);
      OP_AND:  alu_fn = ALUSEL_W'(3);
      OP_OR:   alu_fn = ALUSEL_W'(4);
      OP_XOR:  alu_fn = ALUSEL_W'(5);
      OP_NOT:  alu_fn = ALUSEL_W'(6);
      OP_INC:  alu_fn = ALUSEL_W'(7);
      default: alu_fn = ALUSEL_W'(0);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    arload    = 1'b0;
    arsel     = 1'b0;
    pcinc     = 1'b0;
    pcload    = 1'b0;
    drload    = 1'b0;
    irload    = 1'b0;
    acload    = 1'b0;
    zload     = 1'b0;
    alusel    = ALUSEL_W'(0);
    halted    = 1'b0;

    case (state_q)
      S_INIT: state_d = S_F1;
      S_F1: begin
        arload  = 1'b1;
        state_d = S_F2;
      end
      S_F2: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          drload  = 1'b1;
          pcinc   = 1'b1;
          state_d = S_F3;
        end
      end
      S_F3: begin
        irload  = 1'b1;
        arload  = 1'b1;
        state_d = S_DEC;
      end
      S_DEC: begin
        case (ir_op)
          OP_NOP, OP_NOPD, OP_NOPE:              state_d = S_F1;
          OP_LDAC, OP_STAC, OP_ADD, OP_SUB,
          OP_AND, OP_OR, OP_XOR,
          OP_JUMP, OP_JMPZ, OP_JPNZ:             state_d = S_O1;
          OP_NOT, OP_INC:                        state_d = S_XALU;
          OP_HALT:                               state_d = S_HALT;
          default:                               state_d = S_F1;
        endcase
      end
      S_O1: begin
        // The operand byte is consumed even for branches, so PC always steps past it.
        mem_read = 1'b1;
        if (mem_ready) begin
          drload  = 1'b1;
          pcinc   = 1'b1;
          state_d = is_branch ? S_XJMP : S_O2;
        end
      end
      S_O2: begin
        arload  = 1'b1;
        arsel   = 1'b1;
        state_d = (ir_op == OP_STAC) ? S_XST : S_XLD;
      end
      S_XLD: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          drload  = 1'b1;
          state_d = S_XALU;
        end
      end
      S_XST: begin
        mem_write = 1'b1;
        if (mem_ready) begin
          state_d = S_F1;
        end
      end
      S_XALU: begin
        acload  = 1'b1;
        zload   = 1'b1;
        alusel  = alu_fn;
        state_d = S_F1;
      end
      S_XJMP: begin
        pcload  = (ir_op == OP_JUMP) ||
                  ((ir_op == OP_JMPZ) && zflag) ||
                  ((ir_op == OP_JPNZ) && !zflag);
        state_d = S_F1;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb/tb_cpu_seq_ctrl.sv - scoreboard bench for cpu_seq_ctrl
module tb_cpu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ir_op = 4'h0;
  logic       zflag = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_read, mem_write, arload, arsel, pcinc, pcload;
  logic       drload, irload, acload, zload, halted;
  logic [2:0] alusel;
  logic [3:0] dbg_state;

  cpu_seq_ctrl dut (
    .clk(clk), .rst(rst), .ir_op(ir_op), .zflag(zflag), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .arload(arload), .arsel(arsel),
    .pcinc(pcinc), .pcload(pcload), .drload(drload), .irload(irload),
    .acload(acload), .zload(zload), .alusel(alusel), .halted(halted),
    .dbg_state(dbg_state)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] trace;
    int          len;
    int          pcinc;
    int          pcload;
    int          acload;
    int          wr;
    logic [2:0]  alusel;
  } exp_t;

  exp_t       sb[$];
  int         n_pass = 0;
  int         n_tot  = 0;
  logic [3:0] stall_st = 4'hF;
  int         stall_n = 0;
  int         stall_done = 0;

  wire [9:0]  strobes = {mem_read, mem_write, arload, arsel, pcinc, pcload,
                         drload, irload, acload, zload};
  wire [13:0] outs = {strobes, alusel, halted};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tot++;
    if (act !== req) $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    else n_pass++;
  endtask

  task automatic drive_ready();
    forever begin
      @(negedge clk);
      if (dbg_state == stall_st && stall_done < stall_n) begin
        mem_ready = 1'b0;
        stall_done++;
      end else begin
        mem_ready = 1'b1;
        if (dbg_state != stall_st) stall_done = 0;
      end
    end
  endtask

  task automatic monitor();
    bit          in_i = 0;
    logic [63:0] tr = '0;
    int          len = 0, pi = 0, pl = 0, al = 0, zl = 0, wr = 0, viol = 0;
    logic [2:0]  as = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        in_i = 0;
        continue;
      end
      if (in_i && (dbg_state == 4'd1 || dbg_state == 4'd11)) begin
        chk("sb_level", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({e.name, "_trace"},  tr,  e.trace);
          chk({e.name, "_cycles"}, len, e.len);
          chk({e.name, "_pcinc"},  pi,  e.pcinc);
          chk({e.name, "_pcload"}, pl,  e.pcload);
          chk({e.name, "_acload"}, al,  e.acload);
          chk({e.name, "_zload"},  zl,  e.acload);
          chk({e.name, "_memwr"},  wr,  e.wr);
          chk({e.name, "_alusel"}, as,  e.alusel);
          chk({e.name, "_excl"},   viol, 0);
        end
        in_i = 0;
      end
      if (dbg_state == 4'd1) begin
        in_i = 1; tr = '0; len = 0; pi = 0; pl = 0; al = 0; zl = 0; wr = 0; viol = 0; as = '0;
      end
      if (in_i) begin
        tr = {tr[59:0], dbg_state};
        len++;
        pi += int'(pcinc);
        pl += int'(pcload);
        al += int'(acload);
        zl += int'(zload);
        wr += int'(mem_write);
        if (acload) as = alusel;
        if ((mem_read && mem_write) || (pcinc && pcload)) viol++;
      end
    end
  endtask

  task automatic issue(input string nm, input logic [3:0] op, input logic z,
                       input logic [3:0] st, input int n, input logic [63:0] tr,
                       input int len, input int pi, input int pl, input int al,
                       input int wr, input logic [2:0] as);
    int   k = 0;
    exp_t e;
    do begin
      @(negedge clk);
      #2;
      k++;
    end while (dbg_state != 4'd1 && k < 60);
    if (dbg_state != 4'd1) begin
      chk({nm, "_start_timeout"}, dbg_state, 1);
      return;
    end
    ir_op = op; zflag = z; stall_st = st; stall_n = n;
    e.name = nm; e.trace = tr; e.len = len; e.pcinc = pi; e.pcload = pl;
    e.acload = al; e.wr = wr; e.alusel = as;
    sb.push_back(e);
  endtask

  task automatic stimulus();
    int         k;
    int         hc;
    logic [9:0] any;
    #12;
    chk("rst_state", dbg_state, 0);
    chk("rst_outs", outs, 0);
    @(negedge clk); #3; rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_f1", dbg_state, 1);

    // Abort an instruction while F2 is stalled with mem_read up.
    ir_op = 4'h0; stall_st = 4'd2; stall_n = 100;
    k = 0;
    do begin @(negedge clk); #2; k++; end while (dbg_state != 4'd2 && k < 10);
    chk("f2_reached", dbg_state, 2);
    chk("f2_mem_read", mem_read, 1);
    chk("f2_stall_nodr", {drload, pcinc}, 0);
    #1 rst = 1'b1;
    #1;
    chk("abort_state", dbg_state, 0);
    chk("abort_outs", outs, 0);
    @(negedge clk); #3;
    stall_n = 0; stall_st = 4'hF; rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_f1", dbg_state, 1);

    issue("nop",      4'h0, 0, 4'hF, 0, 64'h1234,       4,  1, 0, 0, 0, 3'd0);
    issue("add",      4'h3, 0, 4'hF, 0, 64'h12345679,   8,  2, 0, 1, 0, 3'd1);
    issue("ldac_f2s", 4'h1, 0, 4'd2, 2, 64'h1222345679, 10, 2, 0, 1, 0, 3'd0);
    issue("stac_xst", 4'h2, 0, 4'd8, 3, 64'h1234568888, 10, 2, 0, 0, 4, 3'd0);
    issue("op5_xlds", 4'h5, 0, 4'd7, 2, 64'h1234567779, 10, 2, 0, 1, 0, 3'd3);
    issue("op4",      4'h4, 0, 4'hF, 0, 64'h12345679,   8,  2, 0, 1, 0, 3'd2);
    issue("op6",      4'h6, 0, 4'hF, 0, 64'h12345679,   8,  2, 0, 1, 0, 3'd4);
    issue("op7",      4'h7, 1, 4'hF, 0, 64'h12345679,   8,  2, 0, 1, 0, 3'd5);
    issue("not",      4'h8, 0, 4'hF, 0, 64'h12349,      5,  1, 0, 1, 0, 3'd6);
    issue("inc",      4'h9, 0, 4'hF, 0, 64'h12349,      5,  1, 0, 1, 0, 3'd7);
    issue("jump",     4'hA, 0, 4'hF, 0, 64'h12345A,     6,  2, 1, 0, 0, 3'd0);
    issue("jmpz_z1",  4'hB, 1, 4'hF, 0, 64'h12345A,     6,  2, 1, 0, 0, 3'd0);
    issue("jmpz_z0",  4'hB, 0, 4'hF, 0, 64'h12345A,     6,  2, 0, 0, 0, 3'd0);
    issue("jpnz_z1",  4'hC, 1, 4'hF, 0, 64'h12345A,     6,  2, 0, 0, 0, 3'd0);
    issue("jpnz_z0",  4'hC, 0, 4'hF, 0, 64'h12345A,     6,  2, 1, 0, 0, 3'd0);
    issue("jmpz_o1s", 4'hB, 1, 4'd5, 1, 64'h123455A,    7,  2, 1, 0, 0, 3'd0);
    issue("nop_d",    4'hD, 0, 4'hF, 0, 64'h1234,       4,  1, 0, 0, 0, 3'd0);
    issue("nop_e",    4'hE, 0, 4'hF, 0, 64'h1234,       4,  1, 0, 0, 0, 3'd0);
    issue("halt",     4'hF, 0, 4'hF, 0, 64'h1234,       4,  1, 0, 0, 0, 3'd0);

    k = 0;
    do begin @(negedge clk); #2; k++; end while (!halted && k < 20);
    chk("halt_reached", halted, 1);
    hc = 0; any = '0;
    repeat (20) begin
      @(negedge clk); #2;
      hc += int'(halted);
      any |= strobes;
    end
    chk("halt_cycles", hc, 20);
    chk("halt_strobes", any, 0);
    chk("halt_state", dbg_state, 11);

    ir_op = 4'h0;
    @(negedge clk); #3; rst = 1'b1;
    #1;
    chk("halt_rst_state", dbg_state, 0);
    chk("halt_rst_outs", outs, 0);
    @(negedge clk); #3; rst = 1'b0;
    @(posedge clk); #1;
    chk("halt_rel_f1", dbg_state, 1);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    fork
      drive_ready();
      monitor();
    join_none
    stimulus();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
